// File: rtl/rv32ima_pkg.sv
// Shared types for the RV32IMA divider: operation encoding, FSM states and datapath width.
package rv32ima_pkg;
  localparam int BIT_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIV_U = 2'b01,
    REM_S = 2'b10,
    REM_U = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } divst_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, try subtracting the divisor.
module div_step
  import rv32ima_pkg::*;
#(
  parameter int WIDTH = BIT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The extra top bit of the trial difference is the borrow: set means "does not fit".
  assign w_shift = {rem_in, quo_in[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, divisor};
  assign rem_out = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~w_trial[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), WIDTH+1 cycles, 1 cycle for special cases.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit
  import rv32ima_pkg::*;
#(
  parameter int WIDTH = BIT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  divst_t           r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvsr, r_out;
  logic             r_neg_q, r_neg_r, r_is_rem, r_dz;

  logic             w_accept, w_sgn, w_neg1, w_neg2;
  logic             w_zero, w_ovf, w_early, w_special, w_last;
  logic [WIDTH-1:0] w_mag1, w_mag2, w_special_res;
  logic [WIDTH-1:0] w_rem_nx, w_quo_nx, w_final;

  assign w_accept = (r_state == IDLE) && start && !flush;
  assign w_sgn    = is_signed_op(div_op);
  assign w_neg1   = w_sgn & in1[WIDTH-1];
  assign w_neg2   = w_sgn & in2[WIDTH-1];
  assign w_mag1   = w_neg1 ? -in1 : in1;
  assign w_mag2   = w_neg2 ? -in2 : in2;
  assign w_zero   = (in2 == '0);
  assign w_ovf    = w_sgn && (in1 == MIN_NEG) && (in2 == '1);
`ifdef DIV_EARLY_OUT_EN
  assign w_early  = !w_zero && (w_mag1 < w_mag2);
`else
  assign w_early  = 1'b0;
`endif
  assign w_special = w_zero | w_ovf | w_early;
  assign w_last    = (r_state == CALC) && (r_count == LAST);

  always_comb begin
    w_special_res = '0;
    if (w_zero)
      w_special_res = is_rem_op(div_op) ? in1 : '1;
    else if (w_ovf)
      w_special_res = is_rem_op(div_op) ? '0 : MIN_NEG;
    else
      w_special_res = is_rem_op(div_op) ? in1 : '0;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_dvsr),
    .rem_out (w_rem_nx),
    .quo_out (w_quo_nx)
  );

  // Sign fix is applied to the final step's output so the result lands in r_out on entry to DONE.
  always_comb begin
    if (r_is_rem)
      w_final = r_neg_r ? -w_rem_nx : w_rem_nx;
    else
      w_final = r_neg_q ? -w_quo_nx : w_quo_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_special ? DONE : CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_out    <= '0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= w_mag1;
      r_dvsr   <= w_mag2;
      r_neg_q  <= w_neg1 ^ w_neg2;
      r_neg_r  <= w_neg1;
      r_is_rem <= is_rem_op(div_op);
      if (w_special) begin
        r_out <= w_special_res;
        r_dz  <= w_zero;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_rem   <= w_rem_nx;
      r_quo   <= w_quo_nx;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_out <= w_final;
        r_dz  <= 1'b0;
      end
    end
  end

  assign out         = r_out;
  assign div_by_zero = r_dz;
endmodule
